soc_design_fb_status_pio: RTL



---
 rtl/soc_design_pio_pkg.sv | 24 ++
 rtl/soc_design_fb_status_pio_if.sv | 13 +
 rtl/soc_design_pio_sync.sv | 24 ++
 rtl/soc_design_fb_status_pio.sv | 97 +++++++++
 4 files changed

// File: rtl/soc_design_pio_pkg.sv
// Shared definitions for the soc_design PIO blocks: register offsets, edge
// selection encodings and the per-bit edge detect helper.
package soc_design_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    function automatic logic [31:0] edge_detect(input int edge_type,
                                                input logic [31:0] cur,
                                                input logic [31:0] last);
        case (edge_type)
            EDGE_FALLING: return ~cur & last;
            EDGE_ANY:     return cur ^ last;
            default:      return cur & ~last;
        endcase
    endfunction

endpackage

// File: rtl/soc_design_fb_status_pio_if.sv
// Avalon-MM slave bus bundle for the 2-bit-address soc_design PIOs.
interface soc_design_fb_status_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata,
                    input  readdata);
    modport slave  (input  address, chipselect, write_n, writedata,
                    output readdata);
endinterface

// File: rtl/soc_design_pio_sync.sv
// WIDTH x SYNC_STAGES flop chain bringing asynchronous inputs into clk.
module soc_design_pio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/soc_design_fb_status_pio.sv
// Frame-buffer status input PIO: synchronized level, per-bit edge capture
// with write-1-to-clear, interrupt mask and a level irq.
module soc_design_fb_status_pio
    import soc_design_pio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_MASK  = 32'h0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    soc_design_fb_status_pio_if.slave   bus,
    input  logic [WIDTH-1:0]            in_port,
    output logic                        irq
);

    localparam int WARM_MAX = SYNC_STAGES + 1;
    localparam int CW       = $clog2(WARM_MAX + 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr;
    logic [31:0]      edges_full;
    logic [CW-1:0]    warm_cnt;
    logic             warm_done;
    logic             wr;

    soc_design_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync)
    );

    assign wr        = bus.chipselect & ~bus.write_n;
    assign warm_done = (warm_cnt == CW'(WARM_MAX));

    // Until the flop chain and prev have filled, the 0 -> input transition
    // out of reset would look like an edge, so detection is held off.
    always_comb begin
        edges_full = edge_detect(EDGE_TYPE, 32'(sync), 32'(prev));
        edges      = warm_done ? edges_full[WIDTH-1:0] : '0;
        clr        = (wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
            prev     <= '0;
        end else begin
            prev <= sync;
            if (!warm_done) begin
                warm_cnt <= warm_cnt + CW'(1);
            end
        end
    end

    // Set has priority over a same-cycle clear so a fresh edge is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~clr) | edges;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= RESET_MASK[WIDTH-1:0];
        end else if (wr && bus.address == ADDR_MASK) begin
            mask <= bus.writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                ADDR_DATA: bus.readdata <= 32'(sync);
                ADDR_MASK: bus.readdata <= 32'(mask);
                ADDR_EDGE: bus.readdata <= 32'(edge_cap);
                default:   bus.readdata <= '0;
            endcase
        end
    end

    assign irq = |(edge_cap & mask);

endmodule
